// File: rtl/payload_pkg.sv
// Shared types and helpers for the payload feeder and its byte decoder.
package payload_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_CHARS = 256;

  typedef enum logic [1:0] {
    StIdle,
    StSod,
    StStream
  } feeder_state_t;

  // Map ASCII 'A'..'Z' onto 'a'..'z'; everything else passes through.
  function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    r = b;
    if (b >= 8'h41 && b <= 8'h5A) begin
      r = b | 8'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/char_onehot_dec.sv
// Registered 8-to-256 character decoder with valid gating.
// The one-hot bus and the byte output are both forced to zero when valid_i is low.
module char_onehot_dec
  import payload_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [BYTE_W-1:0]    char_i,
  output logic                 en_o,
  output logic [BYTE_W-1:0]    char_o,
  output logic [NUM_CHARS-1:0] onehot_o
);

  // Register the decoded character; no bit is set on an invalid cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_o     <= 1'b0;
      char_o   <= '0;
      onehot_o <= '0;
    end else begin
      en_o     <= valid_i;
      char_o   <= valid_i ? char_i : '0;
      onehot_o <= valid_i ? (NUM_CHARS'(1) << char_i) : '0;
    end
  end

endmodule

// File: rtl/payload_byte_feeder.sv
// Serialises a word-wide payload stream to one byte per clock for the payload engines,
// emitting sod before each packet and eop with the final byte.
// Optional: define PAYLOAD_FEEDER_NOCASE_EN to fold 'A'..'Z' to 'a'..'z' before decode.
module payload_byte_feeder
  import payload_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [BYTES-1:0]      s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [NUM_CHARS-1:0]  char_onehot,
  output logic [BYTE_W-1:0]     char_byte,
  output logic                  en,
  output logic                  sod,
  output logic                  eop,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(BYTES + 1);
  localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef logic [BYTES-1:0][BYTE_W-1:0] word_bytes_t;

  feeder_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;   // kept bytes in the held word
  logic [CW-1:0]         ptr_q, ptr_d;   // next byte of the held word to present
  logic                  last_q, last_d;
  logic                  init_q;         // holds s_tready low until the first edge after reset
  logic                  sod_q, sod_d;
  logic                  eop_q, eop_d;

  word_bytes_t   held_bytes, in_bytes, src_bytes;
  logic [CW-1:0] in_cnt, src_cnt, src_ptr;
  logic          src_last, step, accept;
  logic          pres_en;
  logic [BYTE_W-1:0] pres_byte, dec_char;

  // Keep is contiguous from the LSB, so its population count is the byte count.
  function automatic logic [CW-1:0] keep_count(input logic [BYTES-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < BYTES; i++) begin
      c = c + CW'(k[i]);
    end
    return c;
  endfunction

  assign held_bytes = word_q;
  assign in_bytes   = s_tdata;
  assign in_cnt     = keep_count(s_tkeep);

  // Ready in IDLE, or once the held non-final word is exhausted; never looks at s_tvalid.
  assign s_tready = init_q &&
                    ((state_q == StIdle) ||
                     ((state_q == StStream) && (ptr_q == cnt_q) && !last_q));
  assign accept   = s_tvalid && s_tready;

  // Next-state and next-cycle byte selection.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    sod_d     = 1'b0;
    eop_d     = 1'b0;
    pres_en   = 1'b0;
    pres_byte = '0;
    step      = 1'b0;
    src_bytes = held_bytes;
    src_cnt   = cnt_q;
    src_last  = last_q;
    src_ptr   = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          word_d  = s_tdata;
          cnt_d   = in_cnt;
          last_d  = s_tlast;
          ptr_d   = '0;
          sod_d   = 1'b1;
          state_d = StSod;
        end
      end
      StSod: begin
        state_d = StStream;
        step    = 1'b1;
      end
      StStream: begin
        if (ptr_q == cnt_q) begin
          if (last_q) begin
            state_d = StIdle;
          end else if (accept) begin
            // Present byte 0 of the incoming word straight away for gap-free flow.
            word_d    = s_tdata;
            cnt_d     = in_cnt;
            last_d    = s_tlast;
            step      = 1'b1;
            src_bytes = in_bytes;
            src_cnt   = in_cnt;
            src_last  = s_tlast;
            src_ptr   = '0;
          end
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step) begin
      if (src_ptr < src_cnt) begin
        pres_en   = 1'b1;
        pres_byte = src_bytes[src_ptr[IW-1:0]];
        ptr_d     = src_ptr + CW'(1);
        eop_d     = src_last && ((src_ptr + CW'(1)) == src_cnt);
      end else begin
        // Zero-keep word: nothing to present, eop alone if it closes the packet.
        ptr_d = src_ptr;
        eop_d = src_last;
      end
    end
  end

`ifdef PAYLOAD_FEEDER_NOCASE_EN
  assign dec_char = fold_case(pres_byte);
`else
  assign dec_char = pres_byte;
`endif

  // FSM, held word and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      init_q  <= 1'b0;
      sod_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      init_q  <= 1'b1;
      sod_q   <= sod_d;
      eop_q   <= eop_d;
    end
  end

  char_onehot_dec u_dec (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (pres_en),
    .char_i   (dec_char),
    .en_o     (en),
    .char_o   (char_byte),
    .onehot_o (char_onehot)
  );

  assign sod  = sod_q;
  assign eop  = eop_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_payload_byte_feeder.sv
// Self-checking bench for payload_byte_feeder: directed timing scenarios plus randomized
// packets compared against an expected event stream built from the packet contents.
module tb_payload_byte_feeder;

  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [NB-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [255:0]  char_onehot;
  logic [7:0]    char_byte;
  logic          en, sod, eop, busy;

  int checks = 0;
  int errors = 0;
  int onehot_bad = 0;
  // Observed events: {kind, byte}; kind 0=sod, 1=byte, 2=byte with eop, 3=eop without byte.
  logic [9:0] obs_q[$];

  always #5 clk = ~clk;

  payload_byte_feeder #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .char_onehot (char_onehot),
    .char_byte   (char_byte),
    .en          (en),
    .sod         (sod),
    .eop         (eop),
    .busy        (busy)
  );

  function automatic logic [7:0] ref_fold(input logic [7:0] b);
`ifdef PAYLOAD_FEEDER_NOCASE_EN
    if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
`endif
    return b;
  endfunction

  // Monitor: record events and check the one-hot rule every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin
        if (char_onehot !== (256'd1 << char_byte)) onehot_bad++;
      end else if (char_onehot !== '0) begin
        onehot_bad++;
      end
      if (sod) obs_q.push_back({2'd0, 8'h00});
      if (en) obs_q.push_back({(eop ? 2'd2 : 2'd1), char_byte});
      else if (eop) obs_q.push_back({2'd3, 8'h00});
    end
  end

  // Entry/exit invariant of every task: 1 time unit after a rising edge.
  task automatic send_word(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l,
                           input int gap);
    int waited;
    waited = 0;
    s_tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (waited >= 200) begin
      errors++;
      $display("FAIL send_word_timeout: waited %0d cycles, required s_tready within 200", waited);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_tready, en, sod, eop, busy} !== 5'b0 || char_byte !== 8'h00 || char_onehot !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tready=%b en=%b sod=%b eop=%b busy=%b byte=%h, required 0",
               s_tready, en, sod, eop, busy, char_byte);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL tready_before_edge: got %b, required 0", s_tready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL tready_after_release: got %b, required 1", s_tready);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b[5];
    exp_b[0] = 8'h61; exp_b[1] = 8'h72; exp_b[2] = 8'h71; exp_b[3] = 8'h75; exp_b[4] = 8'h65;
    s_tdata = 64'h0000_0065_7571_7261; s_tkeep = 8'h1F; s_tlast = 1'b1; s_tvalid = 1'b1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_idle: got %b, required 1", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (sod !== 1'b1 || en !== 1'b0 || busy !== 1'b1 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL single_sod_cycle: got sod=%b en=%b busy=%b tready=%b, required 1 0 1 0",
               sod, en, busy, s_tready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (en !== 1'b1 || char_byte !== ref_fold(exp_b[i]) || eop !== (i == 4)) begin
        errors++;
        $display("FAIL single_byte%0d: got en=%b byte=%h eop=%b, required en=1 byte=%h eop=%b",
                 i, en, char_byte, eop, ref_fold(exp_b[i]), (i == 4));
      end
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || eop !== 1'b0 || sod !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_after: got en=%b eop=%b sod=%b busy=%b, required all 0",
               en, eop, sod, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] w[2];
    logic [63:0] wsel;
    logic acc;
    int nb, first_en, last_en, rdy_hits, rdy_byte, eop_hits, eop_byte, widx, bad_byte;
    nb = 0; first_en = -1; last_en = -1; rdy_hits = 0; rdy_byte = -1;
    eop_hits = 0; eop_byte = -1; widx = 0; bad_byte = 0;
    w[0] = {$urandom, $urandom};
    w[1] = {$urandom, $urandom};
    s_tdata = w[0]; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (en) begin
        if (nb < 16) begin
          wsel = w[nb / 8];
          if (char_byte !== ref_fold(wsel[8 * (nb % 8) +: 8])) bad_byte++;
        end else begin
          bad_byte++;
        end
        if (s_tready) begin rdy_hits++; rdy_byte = nb; end
        if (eop) begin eop_hits++; eop_byte = nb; end
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        nb++;
      end
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) begin
        widx++;
        if (widx == 1) begin s_tdata = w[1]; s_tlast = 1'b1; end
        else s_tvalid = 1'b0;
      end
    end
    checks++;
    if (nb !== 16 || (last_en - first_en) !== 15) begin
      errors++;
      $display("FAIL b2b_flow: got %0d bytes over span %0d, required 16 over 15", nb,
               last_en - first_en);
    end
    checks++;
    if (rdy_hits !== 1 || rdy_byte !== 7) begin
      errors++;
      $display("FAIL b2b_ready: got %0d hits last at byte %0d, required 1 at byte 7",
               rdy_hits, rdy_byte);
    end
    checks++;
    if (eop_hits !== 1 || eop_byte !== 15) begin
      errors++;
      $display("FAIL b2b_eop: got %0d hits at byte %0d, required 1 at byte 15", eop_hits,
               eop_byte);
    end
    checks++;
    if (bad_byte !== 0) begin
      errors++;
      $display("FAIL b2b_bytes: got %0d wrong bytes, required 0", bad_byte);
    end
  endtask

  task automatic test_stall();
    logic [63:0] w[2];
    logic [63:0] wsel;
    logic acc;
    int nb, phase, dropped, gap, oh_bad, bad_byte;
    nb = 0; phase = 0; dropped = 0; gap = 0; oh_bad = 0; bad_byte = 0;
    w[0] = {$urandom, $urandom};
    w[1] = {$urandom, $urandom};
    s_tdata = w[0]; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (en) begin
        if (nb < 16) begin
          wsel = w[nb / 8];
          if (char_byte !== ref_fold(wsel[8 * (nb % 8) +: 8])) bad_byte++;
        end else begin
          bad_byte++;
        end
        nb++;
      end else if (nb == 8) begin
        gap++;
        if (char_onehot !== '0) oh_bad++;
      end
      if (phase == 1 && nb >= 8) dropped++;
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) begin
        phase++;
        s_tvalid = 1'b0;
      end else if (phase == 1 && dropped == 3) begin
        s_tdata = w[1]; s_tlast = 1'b1; s_tvalid = 1'b1;
      end
    end
    checks++;
    if (nb !== 16 || bad_byte !== 0) begin
      errors++;
      $display("FAIL stall_bytes: got %0d bytes with %0d wrong, required 16 with 0", nb,
               bad_byte);
    end
    checks++;
    if (gap !== 3 || oh_bad !== 0) begin
      errors++;
      $display("FAIL stall_gap: got %0d idle cycles with %0d nonzero onehot, required 3 and 0",
               gap, oh_bad);
    end
  endtask

  task automatic test_empty_and_fold();
    logic [7:0] exp_c;
    s_tdata = {$urandom, $urandom}; s_tkeep = '0; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (sod !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL empty_sod: got sod=%b en=%b, required 1 0", sod, en);
    end
    @(negedge clk);
    checks++;
    if (eop !== 1'b1 || en !== 1'b0 || sod !== 1'b0 || char_onehot !== '0) begin
      errors++;
      $display("FAIL empty_eop: got eop=%b en=%b sod=%b, required 1 0 0 with onehot 0",
               eop, en, sod);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || eop !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: got busy=%b eop=%b, required 0 0", busy, eop);
    end
    @(posedge clk); #1;
    exp_c = ref_fold(8'h4D);
    s_tdata = 64'h4D; s_tkeep = 8'h01; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || eop !== 1'b1 || char_byte !== exp_c) begin
      errors++;
      $display("FAIL fold_byte: got en=%b eop=%b byte=%h, required 1 1 %h", en, eop,
               char_byte, exp_c);
    end
    checks++;
    if (char_onehot[8'h6D] !== (exp_c == 8'h6D) || char_onehot[8'h4D] !== (exp_c == 8'h4D)) begin
      errors++;
      $display("FAIL fold_onehot: got bit6D=%b bit4D=%b, required %b %b", char_onehot[8'h6D],
               char_onehot[8'h4D], (exp_c == 8'h6D), (exp_c == 8'h4D));
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int nb;
    nb = 0;
    s_tdata = {$urandom, $urandom}; s_tkeep = '1; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (en) begin
        nb++;
        if (nb == 3) break;
      end
    end
    checks++;
    if (nb !== 3) begin
      errors++;
      $display("FAIL rstmid_third_byte: got %0d bytes, required 3", nb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_tready, en, sod, eop, busy} !== 5'b0 || char_byte !== 8'h00 || char_onehot !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got tready=%b en=%b sod=%b eop=%b busy=%b, required 0",
               s_tready, en, sod, eop, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_stray: got %0d events after release, required 0", obs_q.size());
    end
  endtask

  task automatic test_random(input int npkt);
    logic [9:0]    exp_q[$];
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic [7:0]    b;
    int nwords, kc, waited;
    logic l;
    obs_q.delete();
    for (int p = 0; p < npkt; p++) begin
      nwords = $urandom_range(1, 4);
      exp_q.push_back({2'd0, 8'h00});
      for (int w = 0; w < nwords; w++) begin
        l = (w == nwords - 1);
        kc = $urandom_range(0, NB);
        k = '0;
        for (int i = 0; i < NB; i++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'h41, 8'h5A)) : 8'($urandom);
          d[8 * i +: 8] = b;
          if (i < kc) begin
            k[i] = 1'b1;
            exp_q.push_back({((l && i == kc - 1) ? 2'd2 : 2'd1), ref_fold(b)});
          end
        end
        if (l && kc == 0) exp_q.push_back({2'd3, 8'h00});
        send_word(d, k, l, $urandom_range(0, 2));
      end
      waited = 0;
      @(negedge clk);
      while (busy !== 1'b0 && waited < 100) begin @(negedge clk); waited++; end
      checks++;
      if (waited >= 100) begin
        errors++;
        $display("FAIL random_drain: packet %0d still busy after %0d cycles, required idle", p,
                 waited);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_event_count: got %0d events, required %0d", obs_q.size(),
               exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_event%0d: got kind=%0d byte=%h, required kind=%0d byte=%h", i,
                 obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_onehot_rule();
    checks++;
    if (onehot_bad !== 0) begin
      errors++;
      $display("FAIL onehot_rule: got %0d bad cycles, required 0", onehot_bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_empty_and_fold();
    test_random(20);
    test_reset_mid();
    test_random(20);
    test_onehot_rule();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
